// File: rtl/background_mem_dp.sv
// background_mem_dp: true dual-port word memory with per-byte write enables
// and an optional background fill engine.
//
// Build option: define BACKGROUND_MEM_DP_FILL_EN to include the fill engine
// (fill_start/fill_value/fill_busy/fill_done). Without it the fill inputs are
// ignored and fill_busy/fill_done are tied low.
//
// Both ports take one access per cycle. Reads return data RD_LATENCY (1 or 2)
// cycles later with readdatavalid; readdata holds between valid cycles.
// Same-cycle writes to one address merge per byte with port A taking
// priority. A read that collides with a write on the other port sees the
// freshly written bytes. Addresses at or above DEPTH drop writes and read
// back zero. INIT_FILE names the image the FPGA build attaches to the RAM
// at configuration time; this RTL carries no initial block of its own.
module background_mem_dp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 4800,
  parameter int RD_LATENCY = 1,
  parameter     INIT_FILE  = "./myBackground.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic                    chipselect,
  input  logic                    chipselect2,
  input  logic                    read,
  input  logic                    read2,
  input  logic                    write,
  input  logic                    write2,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid,
  output logic                    readdatavalid2,
  input  logic                    fill_start,
  input  logic [DATA_WIDTH-1:0]   fill_value,
  output logic                    fill_busy,
  output logic                    fill_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   depth_c   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] last_addr = ADDR_WIDTH'(DEPTH - 1);
  localparam int unused_init_file_bits = $bits(INIT_FILE);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [NB-1:0]         be_t;

  word_t mem [DEPTH];

  // Effective write ports after fill arbitration; slot A carries the fill.
  logic  wr_a_en, wr_b_en;
  addr_t wr_a_addr, wr_b_addr;
  be_t   wr_a_be, wr_b_be;
  word_t wr_a_data, wr_b_data;

  logic  fill_active;
  addr_t fill_addr;
  word_t fill_word;

  addr_t      rd_addr [2];
  logic [1:0] rd_req;
  word_t      rd_word [2];
  logic [1:0] last_valid;
  word_t      last_data [2];

  function automatic logic in_range(input addr_t a);
    return {1'b0, a} < depth_c;
  endfunction

  assign rd_addr[0] = address;
  assign rd_addr[1] = address2;
  // A cycle with both read and write asserted is a write only.
  assign rd_req = {chipselect2 & read2 & ~write2, chipselect & read & ~write};

  // Write arbitration: the fill owns slot A and blocks both external writers.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wr_a_en   = 1'b0;
    wr_a_addr = address;
    wr_a_be   = byteenable;
    wr_a_data = writedata;
    wr_b_en   = 1'b0;
    wr_b_addr = address2;
    wr_b_be   = byteenable2;
    wr_b_data = writedata2;
    if (fill_active) begin
      wr_a_en   = 1'b1;
      wr_a_addr = fill_addr;
      wr_a_be   = '1;
      wr_a_data = fill_word;
    end else begin
      wr_a_en = chipselect  & write  & in_range(address);
      wr_b_en = chipselect2 & write2 & in_range(address2);
    end
  end

  // Byte-granular storage update; A is applied last so it wins on overlap.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset so it maps onto block RAM and
    // keeps its contents across reset; the later non-blocking write wins.
    for (int b = 0; b < NB; b++) begin
      if (wr_b_en && wr_b_be[b]) mem[wr_b_addr][8*b +: 8] <= wr_b_data[8*b +: 8];
      if (wr_a_en && wr_a_be[b]) mem[wr_a_addr][8*b +: 8] <= wr_a_data[8*b +: 8];
    end
  end

  // Read word with same-cycle write bytes forwarded over the stored word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      if (in_range(rd_addr[p])) begin
        rd_word[p] = mem[rd_addr[p]];
        for (int b = 0; b < NB; b++) begin
          if (wr_a_en && wr_a_be[b] && (wr_a_addr == rd_addr[p]))
            rd_word[p][8*b +: 8] = wr_a_data[8*b +: 8];
          else if (wr_b_en && wr_b_be[b] && (wr_b_addr == rd_addr[p]))
            rd_word[p][8*b +: 8] = wr_b_data[8*b +: 8];
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [1:0] s1_valid;
      word_t      s1_data [2];

      // Extra pipeline stage; only the valid bits need flushing on reset.
      always_ff @(posedge clk) begin
        if (reset) s1_valid <= '0;
        else       s1_valid <= rd_req;
        for (int p = 0; p < 2; p++) s1_data[p] <= rd_word[p];
      end

      // Hand the stage-1 results to the output registers.
      always_comb begin
        last_valid = s1_valid;
        for (int p = 0; p < 2; p++) last_data[p] = s1_data[p];
      end
    end else begin : g_lat1
      // Single-cycle latency: output registers load straight from the array.
      always_comb begin
        last_valid = rd_req;
        for (int p = 0; p < 2; p++) last_data[p] = rd_word[p];
      end
    end
  endgenerate

  // Output registers; data only loads on a valid read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdatavalid  <= 1'b0;
      readdatavalid2 <= 1'b0;
      readdata       <= '0;
      readdata2      <= '0;
    end else begin
      readdatavalid  <= last_valid[0];
      readdatavalid2 <= last_valid[1];
      if (last_valid[0]) readdata  <= last_data[0];
      if (last_valid[1]) readdata2 <= last_data[1];
    end
  end

`ifdef BACKGROUND_MEM_DP_FILL_EN
  typedef enum logic {IDLE, FILL} fill_state_t;

  fill_state_t state;
  addr_t       count;
  word_t       fill_latch;

  // Fill FSM: sweep every word once, then pulse fill_done for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            state      <= FILL;
            fill_busy  <= 1'b1;
            fill_latch <= fill_value;
            count      <= '0;
          end
        end
        FILL: begin
          if (count == last_addr) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
      endcase
    end
  end

  // Reset aborts the sweep before the word of the reset cycle is written.
  assign fill_active = (state == FILL) && !reset;
  assign fill_addr   = count;
  assign fill_word   = fill_latch;
`else
  logic unused_fill_inputs;

  assign fill_active        = 1'b0;
  assign fill_addr          = '0;
  assign fill_word          = '0;
  assign fill_busy          = 1'b0;
  assign fill_done          = 1'b0;
  assign unused_fill_inputs = ^{fill_start, fill_value};
`endif

endmodule

// File: tb/tb_background_mem_dp.sv
// Bench for background_mem_dp: one instance per read latency (1 and 2) share
// the stimulus; a scoreboard per output stream holds the expected word and
// the cycle it is due. Fill tests run when BACKGROUND_MEM_DP_FILL_EN is set.
module tb_background_mem_dp;

  localparam int DW    = 16;
  localparam int AW    = 13;
  localparam int DEPTH = 4800;

  typedef struct {
    bit              cs;
    bit              rd;
    bit              wr;
    logic [AW-1:0]   addr;
    logic [1:0]      be;
    logic [DW-1:0]   data;
  } req_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] address, address2;
  logic chipselect, chipselect2, read, read2, write, write2;
  logic [1:0] byteenable, byteenable2;
  logic [DW-1:0] writedata, writedata2;
  logic fill_start;
  logic [DW-1:0] fill_value;

  // Streams: 0/1 = ports A/B of latency-1 DUT, 2/3 = ports A/B of latency-2 DUT.
  logic [DW-1:0] rd [4];
  logic          rv [4];
  logic          busy [2];
  logic          done [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last [4];
  exp_t          sb [4][$];

  always #5 clk = ~clk;

  background_mem_dp #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .address(address), .address2(address2),
    .chipselect(chipselect), .chipselect2(chipselect2),
    .read(read), .read2(read2), .write(write), .write2(write2),
    .byteenable(byteenable), .byteenable2(byteenable2),
    .writedata(writedata), .writedata2(writedata2),
    .readdata(rd[0]), .readdata2(rd[1]),
    .readdatavalid(rv[0]), .readdatavalid2(rv[1]),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(busy[0]), .fill_done(done[0])
  );

  background_mem_dp #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .address(address), .address2(address2),
    .chipselect(chipselect), .chipselect2(chipselect2),
    .read(read), .read2(read2), .write(write), .write2(write2),
    .byteenable(byteenable), .byteenable2(byteenable2),
    .writedata(writedata), .writedata2(writedata2),
    .readdata(rd[2]), .readdata2(rd[3]),
    .readdatavalid(rv[2]), .readdatavalid2(rv[3]),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(busy[1]), .fill_done(done[1])
  );

  function automatic req_t nop();
    req_t r;
    r.cs = 0; r.rd = 0; r.wr = 0; r.addr = '0; r.be = '0; r.data = '0;
    return r;
  endfunction

  function automatic req_t wr_req(input logic [AW-1:0] a, input logic [1:0] be,
                                  input logic [DW-1:0] d);
    req_t r;
    r.cs = 1; r.rd = 0; r.wr = 1; r.addr = a; r.be = be; r.data = d;
    return r;
  endfunction

  function automatic req_t rd_req(input logic [AW-1:0] a);
    req_t r;
    r.cs = 1; r.rd = 1; r.wr = 0; r.addr = a; r.be = '0; r.data = '0;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   op;
    r = nop();
    op = int'($urandom_range(0, 4));
    if ($urandom_range(0, 15) == 0) r.addr = AW'(DEPTH + int'($urandom_range(0, 40)));
    else                            r.addr = AW'($urandom_range(0, 63));
    r.be   = 2'($urandom_range(0, 3));
    r.data = DW'($urandom);
    case (op)
      0: begin r.cs = 0; r.rd = 1'($urandom_range(0, 1)); end
      1, 2: begin r.cs = 1; r.rd = 1; end
      3: begin r.cs = 1; r.wr = 1; end
      default: begin r.cs = 1; r.rd = 1; r.wr = 1; end
    endcase
    return r;
  endfunction

  task automatic idle();
    chipselect = 0; read = 0; write = 0; address = '0; byteenable = '0; writedata = '0;
    chipselect2 = 0; read2 = 0; write2 = 0; address2 = '0; byteenable2 = '0; writedata2 = '0;
  endtask

  task automatic model_write(input req_t r);
    if (int'(r.addr) < DEPTH)
      for (int b = 0; b < 2; b++)
        if (r.be[b]) model[r.addr][8*b +: 8] = r.data[8*b +: 8];
  endtask

  task automatic push(input int p, input logic [AW-1:0] a);
    exp_t e;
    e.data = (int'(a) < DEPTH) ? model[a] : '0;
    e.due  = cyc + 1;
    sb[p].push_back(e);
    e.due  = cyc + 2;
    sb[p+2].push_back(e);
  endtask

  // Compare every output stream against its scoreboard at the falling edge.
  task automatic check_streams();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      if (rv[s] === 1'b1) begin
        total++;
        if (sb[s].size() == 0) begin
          bad++;
          $display("FAIL stray_valid s%0d: valid with data %h at cycle %0d, required no valid", s, rd[s], cyc);
        end else begin
          e = sb[s].pop_front();
          if (rd[s] !== e.data || e.due != cyc) begin
            bad++;
            $display("FAIL read_data s%0d: got %h at cycle %0d, required %h at cycle %0d", s, rd[s], cyc, e.data, e.due);
          end
        end
        last[s] = rd[s];
      end else begin
        if (sb[s].size() != 0 && sb[s][0].due <= cyc) begin
          total++; bad++;
          $display("FAIL missing_valid s%0d: valid=%b at cycle %0d, required %h due cycle %0d", s, rv[s], cyc, sb[s][0].data, sb[s][0].due);
          void'(sb[s].pop_front());
        end
        total++;
        if (rd[s] !== last[s]) begin
          bad++;
          $display("FAIL readdata_hold s%0d: got %h, required held %h", s, rd[s], last[s]);
          last[s] = rd[s];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (!reset) check_streams();
  endtask

  task automatic issue(input req_t a, input req_t b, input bit drop_wr);
    chipselect = a.cs; read = a.rd; write = a.wr; address = a.addr;
    byteenable = a.be; writedata = a.data;
    chipselect2 = b.cs; read2 = b.rd; write2 = b.wr; address2 = b.addr;
    byteenable2 = b.be; writedata2 = b.data;
    if (!drop_wr) begin
      if (b.cs && b.wr) model_write(b);
      if (a.cs && a.wr) model_write(a);
    end
    if (a.cs && a.rd && !a.wr) push(0, a.addr);
    if (b.cs && b.rd && !b.wr) push(1, b.addr);
    tick();
    idle();
  endtask

  task automatic drain();
    repeat (4) tick();
    for (int s = 0; s < 4; s++) begin
      total++;
      if (sb[s].size() != 0) begin
        bad++;
        $display("FAIL leftover s%0d: %0d reads outstanding, required 0", s, sb[s].size());
        sb[s].delete();
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1; fill_start = 0; idle();
    for (int s = 0; s < 4; s++) begin
      sb[s].delete();
      last[s] = '0;
    end
    repeat (n) tick();
    reset = 0;
  endtask

  task automatic check_fill_outputs(input string tag, input logic b_exp, input logic d_exp);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (busy[i] !== b_exp || done[i] !== d_exp) begin
        bad++;
        $display("FAIL %s dut%0d: fill_busy=%b fill_done=%b, required %b %b", tag, i + 1, busy[i], done[i], b_exp, d_exp);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    for (int s = 0; s < 4; s++) begin
      total++;
      if (rv[s] !== 1'b0 || rd[s] !== '0) begin
        bad++;
        $display("FAIL reset_outputs s%0d: valid=%b data=%h, required 0 0000", s, rv[s], rd[s]);
      end
    end
    check_fill_outputs("reset_fill", 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_write_read();
    issue(wr_req(5, 2'b11, 16'hBEEF), nop(), 0);
    issue(nop(), rd_req(5), 0);
    issue(rd_req(5), rd_req(5), 0);
    drain();
  endtask

  task automatic test_dual_write();
    issue(wr_req(9, 2'b10, 16'h1234), wr_req(9, 2'b11, 16'hABCD), 0);
    issue(rd_req(9), nop(), 0);
    drain();
  endtask

  task automatic test_read_during_write();
    issue(wr_req(3, 2'b11, 16'h0000), nop(), 0);
    issue(wr_req(3, 2'b01, 16'h5A5A), rd_req(3), 0);
    issue(rd_req(3), wr_req(3, 2'b10, 16'hC3C3), 0);
    issue(rd_req(3), rd_req(3), 0);
    drain();
  endtask

  task automatic test_read_write_same_port();
    req_t a;
    a = wr_req(20, 2'b11, 16'h1111);
    a.rd = 1;
    issue(a, nop(), 0);
    a = rd_req(20);
    a.cs = 0;
    issue(a, a, 0);
    issue(rd_req(20), nop(), 0);
    drain();
  endtask

  task automatic test_out_of_range();
    issue(wr_req(704, 2'b11, 16'h0704), wr_req(4799, 2'b11, 16'h4799), 0);
    issue(wr_req(4800, 2'b11, 16'hDEAD), wr_req(8191, 2'b11, 16'hBAD1), 0);
    issue(rd_req(4800), rd_req(4799), 0);
    issue(rd_req(8191), rd_req(704), 0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++)
      issue(wr_req(AW'(2*i), 2'b11, DW'($urandom)), wr_req(AW'(2*i + 1), 2'b11, DW'($urandom)), 0);
    for (int n = 0; n < 300; n++) issue(rand_req(), rand_req(), 0);
    drain();
  endtask

`ifdef BACKGROUND_MEM_DP_FILL_EN
  task automatic test_fill();
    int   busy_cnt [2];
    bit   got_done;
    req_t a, b;
    busy_cnt[0] = 0; busy_cnt[1] = 0; got_done = 0;
    issue(wr_req(100, 2'b11, 16'hCAFE), nop(), 0);
    fill_value = 16'h07E0; fill_start = 1;
    tick();
    fill_start = 0;
    for (int n = 0; n < DEPTH + 100; n++) begin
      if (done[0] === 1'b1) begin got_done = 1; break; end
      for (int i = 0; i < 2; i++) if (busy[i] === 1'b1) busy_cnt[i]++;
      a = nop(); b = nop();
      if (busy_cnt[0] == 6)   b = rd_req(4799);
      if (busy_cnt[0] == 301) a = wr_req(150, 2'b11, 16'h1111);
      if (busy_cnt[0] == 21) begin fill_value = 16'hFFFF; fill_start = 1; end
      issue(a, b, busy[0] === 1'b1);
      fill_start = 0;
    end
    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL fill_done_seen: no fill_done within budget, required one pulse");
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (busy_cnt[i] != DEPTH) begin
        bad++;
        $display("FAIL fill_busy_len dut%0d: %0d cycles, required %0d", i + 1, busy_cnt[i], DEPTH);
      end
    end
    check_fill_outputs("fill_done_cycle", 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h07E0;

    // Restart in the fill_done cycle, then abort with reset at fill cycle 100.
    fill_value = 16'h1F1F; fill_start = 1;
    tick();
    fill_start = 0;
    check_fill_outputs("refill_start", 1'b1, 1'b0);
    repeat (100) tick();
    do_reset(1);
    check_fill_outputs("fill_abort", 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      tick();
      check_fill_outputs("after_abort", 1'b0, 1'b0);
    end
    for (int i = 0; i < 100; i++) model[i] = 16'h1F1F;
    issue(rd_req(0), rd_req(2400), 0);
    issue(rd_req(4799), rd_req(99), 0);
    issue(rd_req(100), rd_req(150), 0);
    issue(rd_req(4800), nop(), 0);
    drain();
  endtask
`else
  task automatic test_fill_disabled();
    fill_value = 16'h07E0; fill_start = 1;
    tick();
    fill_start = 0;
    for (int n = 0; n < 5; n++) begin
      check_fill_outputs("fill_disabled", 1'b0, 1'b0);
      tick();
    end
    issue(rd_req(5), rd_req(4800), 0);
    drain();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; fill_start = 0; fill_value = '0; idle();
    test_reset();
    test_write_read();
    test_dual_write();
    test_read_during_write();
    test_read_write_same_port();
    test_out_of_range();
    test_back_to_back();
`ifdef BACKGROUND_MEM_DP_FILL_EN
    test_fill();
`else
    test_fill_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/background_mem_dp.md
BACKGROUND_MEM_DP -- requirements
Module: background_mem_dp

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 13: address width of both ports.
REQ-003 Parameter DEPTH, default 4800: number of words; SHALL satisfy DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter RD_LATENCY, default 1: read latency in cycles; only 1 or 2 legal.
REQ-005 Parameter INIT_FILE, default "./myBackground.hex": power-up memory contents.
REQ-006 One clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-007 Ports, in order (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous active-high reset.
- address / address2  in  ADDR_WIDTH  port A / B word address.
- chipselect / chipselect2  in  1  port A / B select.
- read / read2  in  1  port A / B read request.
- write / write2  in  1  port A / B write request.
- byteenable / byteenable2  in  DATA_WIDTH/8  per-byte write enable.
- writedata / writedata2  in  DATA_WIDTH  write data.
- readdata / readdata2  out  DATA_WIDTH  read data.
- readdatavalid / readdatavalid2  out  1  read data qualifier.
- fill_start  in  1  pulse; start a fill.
- fill_value  in  DATA_WIDTH  fill pattern.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle fill-complete pulse.

Function
REQ-008 Both ports SHALL accept one access per cycle, with no waitrequest.
REQ-009 Write: chipselect & write in cycle N SHALL update enabled bytes at address, visible to reads from cycle N+1.
REQ-010 Read: chipselect & read & ~write in cycle N SHALL assert readdatavalid in cycle N+RD_LATENCY with the word; back-to-back reads SHALL be pipelined at one per cycle.
REQ-011 chipselect with read and write both high SHALL be a write only; no readdatavalid.
REQ-012 readdata SHALL hold its last value when readdatavalid is low.
REQ-013 Address >= DEPTH: write SHALL be dropped; read SHALL return 0 with readdatavalid asserted normally.
REQ-014 Same-cycle writes of both ports to one address: bytes enabled on A SHALL take A data; bytes enabled only on B SHALL take B data.
REQ-015 Mixed-port read-during-write (read on one port, write on the other, same address, same cycle) SHALL return the newly written bytes merged with the old unwritten bytes.
REQ-016 Fill FSM states: IDLE, FILL.
- IDLE -> FILL on fill_start; fill_value latched; counter = 0.
- FILL: write the latched value to counter address, all bytes, one word per cycle, counter 0..DEPTH-1.
- After the write at DEPTH-1 -> IDLE, with fill_done high for exactly the next cycle.
REQ-017 fill_busy SHALL be high exactly during FILL; a fill SHALL take DEPTH cycles.
REQ-018 In FILL, external writes on both ports SHALL be dropped; reads SHALL be served and return current contents.
REQ-019 fill_start while in FILL SHALL be ignored.
REQ-020 fill_start asserted in the same cycle as fill_done SHALL start a new fill.

Reset
REQ-021 reset SHALL force readdatavalid/readdatavalid2 = 0, readdata/readdata2 = 0, flush the read pipeline, FSM = IDLE, fill_busy = 0, fill_done = 0.
REQ-022 reset SHALL NOT alter memory contents.
REQ-023 reset during FILL SHALL abort the fill; already-written words keep the fill value; no fill_done.

Configuration
REQ-024 Macro BACKGROUND_MEM_DP_FILL_EN defined: the fill engine of REQ-016..020 and REQ-023 is present.
REQ-025 Macro not defined: no fill logic; fill_start and fill_value ignored; fill_busy and fill_done tied to 0; all ports still present.

Verification
REQ-026 Write A addr 5 = 0xBEEF, byteenable 2'b11; read B addr 5 next cycle -> readdatavalid2 at +RD_LATENCY, readdata2 = 0xBEEF; repeat with RD_LATENCY = 1 and 2.
REQ-027 Same cycle: A writes addr 9 = 0x1234, be 2'b10; B writes addr 9 = 0xABCD, be 2'b11 -> read addr 9 = 0x12CD.
REQ-028 Addr 3 holds 0x0000; A writes 0x5A5A, be 2'b01, while B reads addr 3 in the same cycle -> readdata2 = 0x005A.
REQ-029 fill_start with fill_value 0x07E0 -> fill_busy high 4800 cycles; fill_done one pulse; reads of addr 0, 2400, 4799 = 0x07E0; A write during fill dropped.
REQ-030 reset at fill cycle 100 -> fill_busy = 0 next cycle; no fill_done; addr 99 = fill value; addr 100 unchanged. Read addr 4800 -> 0 with valid. Without the macro: fill_start -> fill_busy stays 0.
